// File: rtl/text_pkg.sv
// Shared constants, command/state encodings and cursor helpers for the text console writer.
package text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 7;

  typedef enum logic [1:0] {
    CMD_PUT       = 2'd0,
    CMD_NEWLINE   = 2'd1,
    CMD_BACKSPACE = 2'd2,
    CMD_CLEAR     = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROWCLR = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  // Row advance with wrap from the bottom row back to the top.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(ROWS - 1)) ? '0 : r + ROW_W'(1);
  endfunction

endpackage

// File: rtl/text_sweep_ctr.sv
// Row/column sweep counter: walks one row or the whole screen in row-major order.
module text_sweep_ctr
  import text_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             full,
  input  logic [ROW_W-1:0] start_row,
  input  logic             step,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             done_c
);

  logic full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      full_q <= 1'b0;
    end else if (start) begin
      row    <= full ? '0 : start_row;
      col    <= '0;
      full_q <= full;
    end else if (step) begin
      if (col == COL_W'(COLS - 1)) begin
        col <= '0;
        row <= next_row(row);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Current cell is the final one of the sweep.
  assign done_c = (col == COL_W'(COLS - 1)) && (!full_q || row == ROW_W'(ROWS - 1));

endmodule

// File: rtl/text_console_writer.sv
// Console command front end: tracks the cursor and drives the character store write port.
module text_console_writer
  import text_pkg::*;
#(
  parameter logic [3:0] BLANK_CHAR     = 4'h0,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_cmd,
  input  logic [3:0]        in_char,
  output logic [ADDR_W-1:0] waddr,
  output logic [3:0]        new_char,
  output logic              we,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col,
  output logic              busy
);

  state_t            state, state_n;
  logic              boot, boot_n;
  logic [ROW_W-1:0]  row_n;
  logic [COL_W-1:0]  col_n;
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [3:0]        new_char_n;
  logic              busy_n;

  logic              sw_start, sw_full, sw_step, sw_done_c;
  logic [ROW_W-1:0]  sw_start_row, sw_row;
  logic [COL_W-1:0]  sw_col;

  text_sweep_ctr u_sweep (
    .clk       (clk),
    .rst       (rst),
    .start     (sw_start),
    .full      (sw_full),
    .start_row (sw_start_row),
    .step      (sw_step),
    .row       (sw_row),
    .col       (sw_col),
    .done_c    (sw_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      boot       <= CLEAR_ON_RESET;
      cursor_row <= '0;
      cursor_col <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      new_char   <= '0;
      busy       <= CLEAR_ON_RESET;
      in_ready   <= !CLEAR_ON_RESET;
    end else begin
      state      <= state_n;
      boot       <= boot_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      we         <= we_n;
      waddr      <= waddr_n;
      new_char   <= new_char_n;
      busy       <= busy_n;
      in_ready   <= !busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    boot_n       = boot;
    row_n        = cursor_row;
    col_n        = cursor_col;
    we_n         = 1'b0;
    waddr_n      = waddr;
    new_char_n   = new_char;
    sw_start     = 1'b0;
    sw_full      = 1'b0;
    sw_start_row = '0;
    sw_step      = 1'b0;

    unique case (state)
      IDLE: begin
        if (boot) begin
          boot_n   = 1'b0;
          state_n  = CLEAR;
          sw_start = 1'b1;
          sw_full  = 1'b1;
          row_n    = '0;
          col_n    = '0;
        end else if (in_valid && in_ready) begin
          unique case (cmd_t'(in_cmd))
            CMD_PUT: begin
              we_n       = 1'b1;
              waddr_n    = {cursor_row, cursor_col};
              new_char_n = in_char;
              if (cursor_col == COL_W'(COLS - 1)) begin
                row_n        = next_row(cursor_row);
                col_n        = '0;
                state_n      = ROWCLR;
                sw_start     = 1'b1;
                sw_start_row = next_row(cursor_row);
              end else begin
                col_n = cursor_col + COL_W'(1);
              end
            end
            CMD_NEWLINE: begin
              row_n        = next_row(cursor_row);
              col_n        = '0;
              state_n      = ROWCLR;
              sw_start     = 1'b1;
              sw_start_row = next_row(cursor_row);
            end
            CMD_BACKSPACE: begin
              if (cursor_col != '0) begin
                col_n      = cursor_col - COL_W'(1);
                we_n       = 1'b1;
                waddr_n    = {cursor_row, cursor_col - COL_W'(1)};
                new_char_n = BLANK_CHAR;
              end else if (cursor_row != '0) begin
                row_n      = cursor_row - ROW_W'(1);
                col_n      = COL_W'(COLS - 1);
                we_n       = 1'b1;
                waddr_n    = {cursor_row - ROW_W'(1), COL_W'(COLS - 1)};
                new_char_n = BLANK_CHAR;
              end
            end
            CMD_CLEAR: begin
              state_n  = CLEAR;
              sw_start = 1'b1;
              sw_full  = 1'b1;
              row_n    = '0;
              col_n    = '0;
            end
            default: ;
          endcase
        end
      end
      ROWCLR, CLEAR: begin
        sw_step    = 1'b1;
        we_n       = 1'b1;
        waddr_n    = {sw_row, sw_col};
        new_char_n = BLANK_CHAR;
        if (sw_done_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE) || boot_n;
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: command vector table plus sweep and reset sequences.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cmd;
  logic [3:0]  in_char;
  logic [11:0] waddr;
  logic [3:0]  new_char;
  logic        we;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  localparam logic [1:0] PUT = 2'd0, NL = 2'd1, BS = 2'd2, CLR = 2'd3;
  localparam logic [1:0] SW_NONE = 2'd0, SW_ROW = 2'd1, SW_FULL = 2'd2;

  typedef struct {
    logic [1:0]  cmd;
    logic [3:0]  ch;
    logic        we;
    logic [11:0] addr;
    logic [3:0]  nc;
    logic [4:0]  row;
    logic [6:0]  col;
    logic [1:0]  sweep;
    logic [4:0]  srow;
  } vec_t;

  vec_t tab1 [6];
  vec_t tab2 [9];

  text_console_writer #(.BLANK_CHAR(4'h0), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_char    (in_char),
    .waddr      (waddr),
    .new_char   (new_char),
    .we         (we),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts sweep writes until in_ready returns, checking order and blank glyph.
  task automatic check_sweep(input bit full, input logic [4:0] srow);
    int idx = 0;
    int bad = 0;
    int n = full ? 2400 : 80;
    logic [11:0] ea;
    bit saw_busy = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (we) begin
        ea = full ? {5'(idx / 80), 7'(idx % 80)} : {srow, 7'(idx)};
        if (waddr !== ea || new_char !== 4'h0) bad++;
        idx++;
      end
      if (in_ready) break;
      if (busy) saw_busy = 1'b1;
    end
    chk("sweep_count", idx, n);
    chk("sweep_order", bad, 0);
    chk("sweep_busy", int'(saw_busy), 1);
    chk("sweep_end_busy", int'(busy), 0);
  endtask

  task automatic apply(input vec_t v);
    int w = 0;
    while (!in_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_cmd   = v.cmd;
    in_char  = v.ch;
    @(negedge clk);
    in_valid = 1'b0;
    chk("we", int'(we), int'(v.we));
    if (v.we) begin
      chk("waddr", int'(waddr), int'(v.addr));
      chk("new_char", int'(new_char), int'(v.nc));
    end
    chk("cursor_row", int'(cursor_row), int'(v.row));
    chk("cursor_col", int'(cursor_col), int'(v.col));
    if (v.sweep != SW_NONE) check_sweep(v.sweep == SW_FULL, v.srow);
  endtask

  initial begin
    vec_t v;
    //           cmd  ch    we    addr      nc    row    col    sweep    srow
    tab1[0] = '{PUT, 4'h5, 1'b1, 12'h000, 4'h5, 5'd0, 7'd1,  SW_NONE, 5'd0};
    tab1[1] = '{PUT, 4'hA, 1'b1, 12'h001, 4'hA, 5'd0, 7'd2,  SW_NONE, 5'd0};
    tab1[2] = '{NL,  4'h0, 1'b0, 12'h000, 4'h0, 5'd1, 7'd0,  SW_ROW,  5'd1};
    tab1[3] = '{BS,  4'h0, 1'b1, 12'h04F, 4'h0, 5'd0, 7'd79, SW_NONE, 5'd0};
    tab1[4] = '{PUT, 4'hC, 1'b1, 12'h04F, 4'hC, 5'd1, 7'd0,  SW_ROW,  5'd1};
    tab1[5] = '{NL,  4'h0, 1'b0, 12'h000, 4'h0, 5'd2, 7'd0,  SW_ROW,  5'd2};

    tab2[0] = '{NL,  4'h0, 1'b0, 12'h000, 4'h0, 5'd4, 7'd0,  SW_ROW,  5'd4};
    tab2[1] = '{NL,  4'h0, 1'b0, 12'h000, 4'h0, 5'd5, 7'd0,  SW_ROW,  5'd5};
    tab2[2] = '{BS,  4'h0, 1'b1, 12'h24F, 4'h0, 5'd4, 7'd79, SW_NONE, 5'd0};
    tab2[3] = '{PUT, 4'h1, 1'b1, 12'h24F, 4'h1, 5'd5, 7'd0,  SW_ROW,  5'd5};
    tab2[4] = '{PUT, 4'h9, 1'b1, 12'h280, 4'h9, 5'd5, 7'd1,  SW_NONE, 5'd0};
    tab2[5] = '{BS,  4'h0, 1'b1, 12'h280, 4'h0, 5'd5, 7'd0,  SW_NONE, 5'd0};
    tab2[6] = '{CLR, 4'h0, 1'b0, 12'h000, 4'h0, 5'd0, 7'd0,  SW_FULL, 5'd0};
    tab2[7] = '{BS,  4'h0, 1'b0, 12'h000, 4'h0, 5'd0, 7'd0,  SW_NONE, 5'd0};
    tab2[8] = '{PUT, 4'hF, 1'b1, 12'h000, 4'hF, 5'd0, 7'd1,  SW_NONE, 5'd0};

    rst = 1'b1; in_valid = 1'b0; in_cmd = 2'd0; in_char = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_new_char", int'(new_char), 0);
    chk("rst_row", int'(cursor_row), 0);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_ready", int'(in_ready), 0);
    rst = 1'b0;
    check_sweep(1'b1, 5'd0);
    chk("boot_row", int'(cursor_row), 0);
    chk("boot_col", int'(cursor_col), 0);

    foreach (tab1[i]) apply(tab1[i]);

    // 80 back-to-back PUTs fill row 2 and wrap into a row-3 clear
    in_valid = 1'b1; in_cmd = PUT; in_char = 4'h3;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      chk("burst_we", int'(we), 1);
      chk("burst_addr", int'(waddr), int'({5'd2, 7'(i)}));
      chk("burst_char", int'(new_char), 3);
      if (i == 79) in_valid = 1'b0;
    end
    chk("burst_ready", int'(in_ready), 0);
    chk("burst_row", int'(cursor_row), 3);
    chk("burst_col", int'(cursor_col), 0);
    check_sweep(1'b0, 5'd3);

    foreach (tab2[i]) apply(tab2[i]);

    // Walk down to row 29, then wrap back to row 0
    for (int r = 1; r <= 30; r++) begin
      v = '{NL, 4'h0, 1'b0, 12'h000, 4'h0, 5'(r % 30), 7'd0, SW_ROW, 5'(r % 30)};
      apply(v);
    end

    // Reset in the middle of a full clear aborts and restarts it
    v = '{CLR, 4'h0, 1'b0, 12'h000, 4'h0, 5'd0, 7'd0, SW_NONE, 5'd0};
    apply(v);
    repeat (100) @(negedge clk);
    chk("mid_we_active", int'(we), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we", int'(we), 0);
    chk("abort_waddr", int'(waddr), 0);
    chk("abort_row", int'(cursor_row), 0);
    chk("abort_col", int'(cursor_col), 0);
    @(negedge clk);
    rst = 1'b0;
    check_sweep(1'b1, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
